top_out_collector: RTL and testbench
====================================

# top_out_collector

Downstream capture stage for the `top` hierarchy: samples `top`'s `out0` and `bus_out` every clock and detects changes in the 3-bit output vector. Each change becomes a timestamped event in a small first-word-fall-through FIFO, drained through a valid/ready handshake. Gives netlist-transform regression benches a cycle-accurate record of `top` output activity.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `TS_W`, 8, timestamp width in bits.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `out0`  in  1  from `top.out0`.
- `bus_out`  in  2  from `top.bus_out`.
- `capture_en`  in  1  enables event generation.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head.
- `evt_data`  out  TS_W+3  `{ts, out0, bus_out}` of the head entry.
- `evt_count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; an event was dropped.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Sample stage: `s1 <= {out0, bus_out}` every edge; `s2 <= s1` every edge. Both update regardless of `capture_en`.
- Priming: no event until `s2` holds a real sample. The first compare is in the cycle after the 2nd edge following reset release.
- Change: `chg = primed && capture_en && (s1 != s2)`.
- Timestamp: `ts` is a free-running counter. Reset value 0, +1 every edge, wraps `2^TS_W-1 → 0` silently. On a change, the entry pushed is `{ts, s1}`, using `ts` as it stands in the detect cycle.
- FIFO: first-word-fall-through. `evt_valid = (evt_count != 0)`; `evt_data` is the head entry.
  - Pop: `evt_valid && evt_ready`.
  - Push: `chg && (!full || pop)`.
  - Full with pop: push and pop are both accepted and the count is unchanged.
  - Empty with `chg`: push only; the data becomes visible the next cycle (no bypass).
  - Full without pop and `chg`: the event is dropped, `overflow <= 1`, and the FIFO is unchanged.
- `overflow`: `clr_overflow` clears it. If set and clear occur in the same cycle, set wins.
- `evt_ready` while empty: ignored, no state change.
- `capture_en` low: changes are not recorded. On re-enable, the first compare uses the current `s1`/`s2`, so a difference present in that cycle produces an event.

## Timing
- Reset values: `evt_valid` 0, `evt_data` 0, `evt_count` 0, `overflow` 0, `ts` 0, `s1`/`s2` 0, `primed` 0.
- Reset mid-operation flushes all entries, clears `overflow`, restarts `ts` and priming. Nothing is retained.
- Latency: an input change stable before edge k is captured in `s1` at k and pushed at k+1. `evt_valid` is high after edge k+1, with `ts = k` (edges counted from reset release).
- One push and one pop per cycle maximum. Throughput is one event per cycle when the consumer keeps `evt_ready` high.
- `evt_data` and `evt_valid` are registered or FIFO-RAM outputs, with no combinational path from `evt_ready`.
- `evt_count` updates at the same edge as the push or pop.

## Structure
- Package `top_out_collector_pkg`:
  - `SMP_W = 3`
  - default `TS_W`
  - packed struct `evt_t {logic [TS_W-1:0] ts; logic out0; logic [1:0] bus_out;}`
  - localparams for the field offsets
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`): storage, read/write pointers of `$clog2(DEPTH)` bits plus a count, push/pop/full/empty. Reused elsewhere.
- Top level holds the sample registers, priming, `ts` counter, change detection and overflow flag.

## Test plan
- Reset, then hold inputs at 0 with `capture_en=1` for 20 cycles → `evt_valid` stays 0, `evt_count` stays 0.
- Change `{out0,bus_out}` from `3'b000` to `3'b110` just before edge 10 → after edge 11, `evt_valid=1` and `evt_data={8'd10,1'b1,2'b10}`.
- `evt_ready=0`, six single-cycle changes at 2-cycle spacing, `DEPTH=4` → `evt_count=4`, `overflow=1`. Then drain → the four oldest events come out in order.
- Full FIFO, change plus `evt_ready=1` in the same cycle → count stays 4, the head advances, and the new event is at the tail.
- `clr_overflow` asserted in the same cycle as a dropped push → `overflow` remains 1. `clr_overflow` alone next cycle → 0.
- Pulse `rst_n` low for 1 cycle with 3 entries queued → the next cycle has `evt_valid=0`, `evt_count=0`, `ts=0`. No event for an input change until priming completes.

Source files
------------

// File: rtl/top_out_collector_pkg.sv
// Shared types and constants for the top output collector.
// An event word is {ts, out0, bus_out}, with the timestamp in the high bits.
package top_out_collector_pkg;
  localparam int SMP_W    = 3;
  localparam int TS_W_DEF = 8;

  // Bit offsets inside an event word
  localparam int BUS_LSB  = 0;
  localparam int OUT0_BIT = 2;
  localparam int TS_LSB   = SMP_W;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic                out0;
    logic [1:0]          bus_out;
  } evt_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered storage and a read mux.
// A pop on an empty FIFO is ignored. A push on a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // No bypass: an empty FIFO reports zero, never the write data.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/top_out_collector.sv
// Samples top's {out0, bus_out} on every clock. Each change of that vector is queued as a timestamped event.
// Events are drained through a valid/ready handshake. A full FIFO drops the event and sets the sticky overflow flag.
module top_out_collector
  import top_out_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    out0,
  input  logic [1:0]              bus_out,
  input  logic                    capture_en,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [TS_W+SMP_W-1:0]   evt_data,
  output logic [$clog2(DEPTH):0]  evt_count,
  output logic                    overflow,
  input  logic                    clr_overflow
);
  logic [SMP_W-1:0] s1, s2;
  logic [1:0]       prime_cnt;
  logic [TS_W-1:0]  ts;
  logic             primed, chg, pop, drop, full, empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      prime_cnt <= '0;
      ts        <= '0;
    end else begin
      s1 <= {out0, bus_out};
      s2 <= s1;
      ts <= ts + 1'b1;
      // s2 holds a real sample after the second edge out of reset
      if (!prime_cnt[1]) prime_cnt <= prime_cnt + 1'b1;
    end
  end

  assign primed    = prime_cnt[1];
  assign chg       = primed && capture_en && (s1 != s2);
  assign pop       = evt_valid && evt_ready;
  assign drop      = chg && full && !pop;
  assign evt_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  sync_fifo #(.WIDTH(TS_W+SMP_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (chg),
    .wdata ({ts, s1}),
    .pop   (evt_ready),
    .rdata (evt_data),
    .full  (full),
    .empty (empty),
    .count (evt_count)
  );
endmodule

// File: tb/tb_top_out_collector.sv
// Directed bench for top_out_collector. Inputs are driven and outputs checked on the falling edge.
// e counts rising edges since reset release.
module tb_top_out_collector;
  logic        clk = 1'b0;
  logic        rst_n, out0, capture_en, evt_ready, clr_overflow;
  logic [1:0]  bus_out;
  logic        evt_valid, overflow;
  logic [10:0] evt_data;
  logic [2:0]  evt_count;
  int          checks = 0, errors = 0, e = 0;

  always #5 clk = ~clk;

  top_out_collector #(.DEPTH(4), .TS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .out0(out0), .bus_out(bus_out),
    .capture_en(capture_en), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_count(evt_count), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic set_in(input logic [2:0] v);
    {out0, bus_out} = v;
  endtask

  initial begin
    rst_n = 1'b0; capture_en = 1'b1; evt_ready = 1'b0; clr_overflow = 1'b0;
    set_in(3'b000);
    repeat (2) @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ts", dut.ts, 0);

    rst_n = 1'b1; e = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("idle_valid", evt_valid, 0);
      chk("idle_count", evt_count, 0);
    end

    // First event: the change lands in s1 at edge 10 and is pushed at edge 11 with ts=10
    set_in(3'b110);
    tick(1);
    chk("lat_not_yet", evt_valid, 0);
    tick(1);
    chk("lat_valid", evt_valid, 1);
    chk("lat_data", evt_data, {8'd10, 3'b110});
    chk("lat_count", evt_count, 1);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    chk("pop1_count", evt_count, 0);
    chk("pop1_data", evt_data, 0);

    // Six changes 2 cycles apart with the consumer stalled; events carry ts 13, 15, 17, 19, 21, 23
    set_in(3'b001); tick(2);
    set_in(3'b010); tick(2);
    set_in(3'b011); tick(2);
    set_in(3'b100); tick(2);
    set_in(3'b101); tick(2);
    set_in(3'b111); tick(2);
    chk("full_count", evt_count, 4);
    chk("full_ovf", overflow, 1);
    chk("full_head", evt_data, {8'd13, 3'b001});

    // Full FIFO: a push and a pop in the same cycle keep the count at 4
    set_in(3'b000); tick(1);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    chk("fullpop_count", evt_count, 4);
    chk("fullpop_head", evt_data, {8'd15, 3'b010});

    // A dropped push and clr_overflow in the same cycle: the set wins
    set_in(3'b101); tick(1);
    clr_overflow = 1'b1; tick(1);
    chk("setwins_ovf", overflow, 1);
    tick(1); clr_overflow = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("drop_count", evt_count, 4);

    evt_ready = 1'b1;
    chk("drain0", evt_data, {8'd15, 3'b010}); tick(1);
    chk("drain1", evt_data, {8'd17, 3'b011}); tick(1);
    chk("drain2", evt_data, {8'd19, 3'b100}); tick(1);
    chk("drain3", evt_data, {8'd25, 3'b000}); tick(1);
    chk("drained_valid", evt_valid, 0);
    tick(1);
    chk("ready_empty_count", evt_count, 0);
    evt_ready = 1'b0;

    // Changes are ignored while capture is disabled; a difference still present at re-enable is recorded
    capture_en = 1'b0; set_in(3'b010); tick(3);
    chk("dis_count", evt_count, 0);
    set_in(3'b011); tick(1);
    capture_en = 1'b1; tick(1);
    chk("reen_count", evt_count, 1);
    chk("reen_data", evt_data, {8'd38, 3'b011});

    set_in(3'b100); tick(2);
    set_in(3'b101); tick(2);
    chk("pre_rst_count", evt_count, 3);

    // Reset in mid-operation flushes the FIFO and restarts priming
    rst_n = 1'b0; set_in(3'b110); @(negedge clk); rst_n = 1'b1; e = 0;
    chk("mrst_valid", evt_valid, 0);
    chk("mrst_count", evt_count, 0);
    chk("mrst_ts", dut.ts, 0);
    chk("mrst_data", evt_data, 0);
    tick(2);
    chk("prime_count", evt_count, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("hold_count", evt_count, 0);
    end
    set_in(3'b000); tick(2);
    chk("post_prime_data", evt_data, {8'd23, 3'b000});
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;

    // The timestamp wraps silently from 255 to 0
    tick(230);
    chk("ts_255", dut.ts, 255);
    set_in(3'b111); tick(1);
    chk("ts_wrap", dut.ts, 0);
    tick(1);
    chk("wrap_data", evt_data, {8'd0, 3'b111});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
